// File: rtl/button_debouncer_pkg.sv
// Shared defaults, per-channel state encoding and the stable-time helper
// for the push-button debouncer.
package button_debouncer_pkg;

    localparam int DEFAULT_CLK_HZ      = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_MS = 10;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    // Division happens first so a 50 MHz clock does not overflow 32 bits.
    function automatic int stable_cycles(input int clk_hz, input int debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: synchroniser chain, qualification counter,
// STABLE/PENDING state machine and registered rise/fall strobes.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  STABLE  | synchronised input equals clean level, counter held at 0
//  PENDING | synchronised input differs from clean, counting stable time
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;

    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Reject takes priority over accept: a return to the clean level on the
    // final counting edge still discards the transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sync_bit != clean_q) begin
                    state_d = PENDING;
                    cnt_d   = CNT_ONE;
                end
            end
            PENDING: begin
                if (sync_bit == clean_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    clean_d = sync_bit;
                    rise_d  = sync_bit;
                    fall_d  = ~sync_bit;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button conditioner: one independent debounce channel per
// input bit, clean levels plus one-cycle rise/fall strobes.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int CLK_HZ      = DEFAULT_CLK_HZ,
    parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_clean,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall
);

    localparam int STABLE_CYCLES = stable_cycles(CLK_HZ, DEBOUNCE_MS);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debouncer: SYNC_STAGES must be >= 2");
    end
    if (CHANNELS < 1) begin : g_bad_chan
        $error("button_debouncer: CHANNELS must be >= 1");
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[ch]),
            .clean (btn_clean[ch]),
            .rise  (btn_rise[ch]),
            .fall  (btn_fall[ch])
        );
    end

endmodule
